// File: rtl/crc16_rx_check.sv
// CRC-16 receive checker: regenerates the CRC over a serial MSB-first frame,
// forwards payload bytes to the rx FIFO and flags pass/fail per frame.
// Ports: clk, rst (async active-low), sof/bit_valid/bit_in/eof serial input;
//        data_out/wrreq FIFO write; crc_calc/crc_rx/busy/crc_done/crc_ok/frame_err status.
module crc16_rx_check #(
  parameter logic [15:0] POLYNOMIAL        = 16'h8005,
  parameter logic [15:0] INITIAL_CRC_VALUE = 16'h4F4E
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sof,
  input  logic        bit_valid,
  input  logic        bit_in,
  input  logic        eof,
  output logic [7:0]  data_out,
  output logic        wrreq,
  output logic [15:0] crc_calc,
  output logic [15:0] crc_rx,
  output logic        busy,
  output logic        crc_done,
  output logic        crc_ok,
  output logic        frame_err
);

  typedef enum logic {IDLE, RECV} state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] crc_calc_q, crc_calc_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  hold_cnt_q, hold_cnt_d;
  logic [7:0]  byte_sr_q, byte_sr_d;
  logic [7:0]  hold1_q, hold1_d;
  logic [7:0]  hold0_q, hold0_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        wrreq_q, wrreq_d;
  logic        busy_q, busy_d;
  logic        crc_done_q, crc_done_d;
  logic        crc_ok_q, crc_ok_d;
  logic        frame_err_q, frame_err_d;

  // Frame-start values are folded in first so a sof bit is the first frame bit.
  logic [15:0] base_lfsr;
  logic [2:0]  base_cnt;
  logic [1:0]  base_hcnt;
  logic        active;
  logic        fb;
  logic [15:0] lfsr_n;
  logic [7:0]  sr_n;
  logic        err;

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    crc_calc_d  = crc_calc_q;
    bit_cnt_d   = bit_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    byte_sr_d   = byte_sr_q;
    hold1_d     = hold1_q;
    hold0_d     = hold0_q;
    data_out_d  = data_out_q;
    wrreq_d     = 1'b0;
    busy_d      = busy_q;
    crc_done_d  = 1'b0;
    crc_ok_d    = crc_ok_q;
    frame_err_d = frame_err_q;
    base_lfsr   = lfsr_q;
    base_cnt    = bit_cnt_q;
    base_hcnt   = hold_cnt_q;
    active      = (state_q == RECV);
    fb          = 1'b0;
    lfsr_n      = lfsr_q;
    sr_n        = byte_sr_q;
    err         = 1'b0;

    if (sof) begin
      base_lfsr   = INITIAL_CRC_VALUE;
      base_cnt    = 3'd0;
      base_hcnt   = 2'd0;
      active      = 1'b1;
      state_d     = RECV;
      busy_d      = 1'b1;
      lfsr_d      = INITIAL_CRC_VALUE;
      bit_cnt_d   = 3'd0;
      hold_cnt_d  = 2'd0;
      crc_ok_d    = 1'b0;
      frame_err_d = 1'b0;
    end

    if (active && bit_valid) begin
      fb         = bit_in ^ base_lfsr[15];
      lfsr_n     = {base_lfsr[14:0], 1'b0} ^ (fb ? POLYNOMIAL : 16'h0000);
      sr_n       = {byte_sr_q[6:0], bit_in};
      lfsr_d     = lfsr_n;
      crc_calc_d = lfsr_n;
      byte_sr_d  = sr_n;
      bit_cnt_d  = base_cnt + 3'd1;
      if (base_cnt == 3'd7) begin
        // Two-deep hold pipe keeps the trailing CRC bytes out of the FIFO.
        if (base_hcnt == 2'd2) begin
          wrreq_d    = 1'b1;
          data_out_d = hold1_q;
        end
        hold1_d    = hold0_q;
        hold0_d    = sr_n;
        hold_cnt_d = (base_hcnt == 2'd2) ? 2'd2 : base_hcnt + 2'd1;
      end
      if (eof) begin
        // A complete final byte brings the count up by one, so one prior
        // complete byte is the minimum for a two-byte frame.
        err         = (base_cnt != 3'd7) || (base_hcnt == 2'd0);
        crc_done_d  = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
        frame_err_d = err;
        crc_ok_d    = (lfsr_n == 16'h0000) && !err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      lfsr_q      <= INITIAL_CRC_VALUE;
      crc_calc_q  <= 16'h0000;
      bit_cnt_q   <= 3'd0;
      hold_cnt_q  <= 2'd0;
      byte_sr_q   <= 8'h00;
      hold1_q     <= 8'h00;
      hold0_q     <= 8'h00;
      data_out_q  <= 8'h00;
      wrreq_q     <= 1'b0;
      busy_q      <= 1'b0;
      crc_done_q  <= 1'b0;
      crc_ok_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      crc_calc_q  <= crc_calc_d;
      bit_cnt_q   <= bit_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      byte_sr_q   <= byte_sr_d;
      hold1_q     <= hold1_d;
      hold0_q     <= hold0_d;
      data_out_q  <= data_out_d;
      wrreq_q     <= wrreq_d;
      busy_q      <= busy_d;
      crc_done_q  <= crc_done_d;
      crc_ok_q    <= crc_ok_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign data_out  = data_out_q;
  assign wrreq     = wrreq_q;
  assign crc_calc  = crc_calc_q;
  assign crc_rx    = {hold1_q, hold0_q};
  assign busy      = busy_q;
  assign crc_done  = crc_done_q;
  assign crc_ok    = crc_ok_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_crc16_rx_check.sv
// Bench for crc16_rx_check: directed frames with a scoreboard of
// expected FIFO writes and per-frame results.
module tb_crc16_rx_check;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sof = 1'b0;
  logic        bit_valid = 1'b0;
  logic        bit_in = 1'b0;
  logic        eof = 1'b0;
  logic [7:0]  data_out;
  logic        wrreq;
  logic [15:0] crc_calc;
  logic [15:0] crc_rx;
  logic        busy;
  logic        crc_done;
  logic        crc_ok;
  logic        frame_err;

  crc16_rx_check dut (
    .clk(clk), .rst(rst), .sof(sof), .bit_valid(bit_valid),
    .bit_in(bit_in), .eof(eof), .data_out(data_out), .wrreq(wrreq),
    .crc_calc(crc_calc), .crc_rx(crc_rx), .busy(busy),
    .crc_done(crc_done), .crc_ok(crc_ok), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ok;
    logic        err;
    logic [15:0] rx;
    logic        chk_rx;
    logic [15:0] calc;
  } res_t;

  logic [7:0] wq[$];
  res_t       rq[$];
  res_t       r;
  int errors = 0;
  int checks = 0;
  int wr_seen = 0;
  int done_seen = 0;
  int wr0, dn0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] step(input logic [15:0] l, input logic b);
    logic f;
    f = b ^ l[15];
    return {l[14:0], 1'b0} ^ (f ? 16'h8005 : 16'h0000);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (wrreq) begin
        wr_seen++;
        if (wq.size() == 0) chk("wr_unexpected", 1, 0);
        else chk("wr_data", {24'h0, data_out}, {24'h0, wq.pop_front()});
      end
      if (crc_done) begin
        done_seen++;
        if (rq.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          r = rq.pop_front();
          chk("done_ok", {31'h0, crc_ok}, {31'h0, r.ok});
          chk("done_err", {31'h0, frame_err}, {31'h0, r.err});
          chk("done_calc", {16'h0, crc_calc}, {16'h0, r.calc});
          if (r.chk_rx) chk("done_rx", {16'h0, crc_rx}, {16'h0, r.rx});
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, input int n, input bit eof_last,
                      input bit gaps, input bit use_sof);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
          sof = 1'b0; bit_valid = 1'b0; eof = 1'b0;
        end
      end
      @(posedge clk); #1;
      sof       = use_sof && (i == 0);
      bit_valid = 1'b1;
      bit_in    = d[n-1-i];
      eof       = eof_last && (i == n - 1);
    end
    @(posedge clk); #1;
    sof = 1'b0; bit_valid = 1'b0; eof = 1'b0; bit_in = 1'b0;
  endtask

  task automatic expect_frame(input logic [31:0] d, input int n);
    res_t e;
    logic [15:0] l;
    int nb;
    nb = n / 8;
    l = 16'h4F4E;
    for (int i = 0; i < n; i++) l = step(l, d[n-1-i]);
    e.err    = (n % 8 != 0) || (nb < 2);
    e.ok     = (l == 16'h0000) && !e.err;
    e.calc   = l;
    e.chk_rx = !e.err;
    e.rx     = d[15:0];
    if (!e.err)
      for (int k = 0; k < nb - 2; k++) wq.push_back(d[n-1-8*k -: 8]);
    rq.push_back(e);
  endtask

  task automatic run_frame(input logic [31:0] d, input int n, input bit gaps);
    wr0 = wr_seen;
    dn0 = done_seen;
    expect_frame(d, n);
    send(d, n, 1'b1, gaps, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("frame_done_cnt", done_seen - dn0, 1);
    chk("wq_drained", wq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    chk("busy_after", {31'h0, busy}, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"}, {24'h0, data_out}, 0);
    chk({tag, "_wrreq"}, {31'h0, wrreq}, 0);
    chk({tag, "_calc"}, {16'h0, crc_calc}, 0);
    chk({tag, "_rx"}, {16'h0, crc_rx}, 0);
    chk({tag, "_busy"}, {31'h0, busy}, 0);
    chk({tag, "_done"}, {31'h0, crc_done}, 0);
    chk({tag, "_ok"}, {31'h0, crc_ok}, 0);
    chk({tag, "_err"}, {31'h0, frame_err}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b1;

    // Good frame: one payload byte, CRC CFA1.
    run_frame(32'h0000CFA1, 24, 1'b0);
    chk("t1_wr", wr_seen - wr0, 1);
    chk("t1_ok", {31'h0, crc_ok}, 1);
    chk("t1_err", {31'h0, frame_err}, 0);
    chk("t1_rx", {16'h0, crc_rx}, 32'hCFA1);
    chk("t1_calc", {16'h0, crc_calc}, 0);

    // Corrupted CRC.
    run_frame(32'h0000CFA0, 24, 1'b0);
    chk("t2_wr", wr_seen - wr0, 1);
    chk("t2_ok", {31'h0, crc_ok}, 0);
    chk("t2_err", {31'h0, frame_err}, 0);
    chk("t2_rx", {16'h0, crc_rx}, 32'hCFA0);

    // Empty payload: CRC of nothing is the preset.
    run_frame(32'h00004F4E, 16, 1'b0);
    chk("t3_wr", wr_seen - wr0, 0);
    chk("t3_ok", {31'h0, crc_ok}, 1);
    chk("t3_rx", {16'h0, crc_rx}, 32'h4F4E);

    // Partial byte at eof.
    run_frame(32'h000000CF, 12, 1'b0);
    chk("t4_wr", wr_seen - wr0, 0);
    chk("t4_ok", {31'h0, crc_ok}, 0);
    chk("t4_err", {31'h0, frame_err}, 1);

    // Aborted frame with gaps, then restart with sof on a valid bit.
    wr0 = wr_seen;
    dn0 = done_seen;
    send(32'h0000CFA1, 20, 1'b0, 1'b1, 1'b1);
    chk("t5_busy_mid", {31'h0, busy}, 1);
    chk("t5_no_done", done_seen - dn0, 0);
    run_frame(32'h0000CFA1, 24, 1'b1);
    chk("t5_wr", wr_seen - wr0, 1);
    chk("t5_ok", {31'h0, crc_ok}, 1);

    // Reset mid-frame.
    send(32'h0000CFA1, 10, 1'b0, 1'b0, 1'b1);
    #1 rst = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(posedge clk); #1;
    rst = 1'b1;
    wr0 = wr_seen;
    dn0 = done_seen;
    send(32'h00004F4E, 16, 1'b1, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("t6_ignored_done", done_seen - dn0, 0);
    chk("t6_ignored_wr", wr_seen - wr0, 0);
    chk("t6_busy", {31'h0, busy}, 0);
    run_frame(32'h0000CFA1, 24, 1'b0);
    chk("t6_wr", wr_seen - wr0, 1);
    chk("t6_ok", {31'h0, crc_ok}, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/crc16_rx_check.md
Name: crc16_rx_check

Overview:
- Receive-side counterpart of the CRC-16 transmit generator.
- Accepts a serial MSB-first bit stream whose last 16 bits are the transmitted CRC, and regenerates the CRC over the whole frame with the same LFSR.
- Assembles payload bytes and writes them to the receive buffer, excluding the two CRC bytes.
- Reports pass/fail per frame. Sits between the serial link deserializer and the receive data FIFO.

Parameters:
- POLYNOMIAL, 16'h8005, CRC generator polynomial (non-reflected, no final XOR).
- INITIAL_CRC_VALUE, 16'h4F4E, LFSR preset loaded at frame start.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- sof  input  1  one-cycle frame-start pulse
- bit_valid  input  1  bit_in carries a frame bit this cycle
- bit_in  input  1  serial data, MSB of each byte first
- eof  input  1  marks the last frame bit; qualified by bit_valid
- data_out  output  8  payload byte to the FIFO
- wrreq  output  1  one-cycle FIFO write strobe for data_out
- crc_calc  output  16  running LFSR value
- crc_rx  output  16  last two received bytes, {older, newer}
- busy  output  1  frame in progress
- crc_done  output  1  one-cycle pulse; frame result valid
- crc_ok  output  1  frame passed; held until next sof
- frame_err  output  1  malformed frame; held until next sof

Behaviour:
- Reset values: all outputs 0; lfsr = INITIAL_CRC_VALUE; state IDLE; counters 0.
- LFSR step per accepted bit:
  - fb = bit_in ^ lfsr[15]
  - lfsr = {lfsr[14:0],1'b0} ^ (fb ? POLYNOMIAL : 0)
- States:
  - IDLE: bit_valid and eof are ignored without sof. On sof: lfsr = INIT, bit_cnt = 0, hold_cnt = 0, crc_ok = 0, frame_err = 0, go to RECV, busy = 1.
  - RECV: each bit_valid steps the LFSR and shifts the bit into byte_sr. bit_cnt (3-bit) increments and wraps 7→0.
  - RECV, byte complete (bit_cnt==7 with bit_valid): the new byte enters a 2-deep hold pipe (hold1 = older, hold0 = newer).
    - If hold_cnt==2, hold1 is emitted: data_out = hold1 and wrreq = 1 on the next cycle.
    - Then hold1 = hold0, hold0 = new byte, and hold_cnt saturates at 2.
  - RECV, eof with bit_valid: that bit is processed normally. Next cycle: crc_done = 1, busy = 0, return to IDLE.
- The final two bytes are never written to the FIFO; crc_rx = {hold1, hold0}.
- Result evaluation (after the eof bit):
  - frame_err = 1 if bit_cnt was not 7 at eof, or fewer than 2 complete bytes were received.
  - crc_ok = (lfsr after eof bit == 16'h0000) && !frame_err.
- Latency: wrreq and crc_done are registered, appearing 1 cycle after the bit that triggers them. When one bit both completes a byte and is eof, wrreq and crc_done assert in the same cycle.
- sof with bit_valid in the same cycle: the frame is re-initialised and that bit is the first frame bit (lfsr = step(INIT, bit_in)).
- sof during RECV: current frame is aborted with no crc_done and no pending write of held bytes; the new frame starts.
- Gaps (bit_valid = 0) anywhere in RECV are allowed; all state holds.
- crc_calc updates every accepted bit; crc_rx updates at every byte completion.
- Reset mid-frame: everything returns to reset values immediately; no further wrreq.

Test Plan:
- Frame bytes 00 CF A1, eof on last bit → one wrreq with data_out = 8'h00; crc_done pulse; crc_ok = 1; frame_err = 0; crc_rx = 16'hCFA1; crc_calc = 0 at done.
- Frame 00 CF A0 → wrreq 8'h00; crc_done; crc_ok = 0; frame_err = 0; crc_rx = 16'hCFA0.
- Empty payload, frame bytes 4F 4E → no wrreq; crc_ok = 1; crc_rx = 16'h4F4E.
- eof after 12 bits (1.5 bytes) → crc_done; frame_err = 1; crc_ok = 0; no wrreq.
- Frame 00 CF A1 with random bit_valid gaps, then sof mid-frame of a second identical frame → first frame gives no crc_done; second gives exactly one wrreq of 8'h00 and crc_ok = 1.
- rst asserted after 10 bits of a frame → all outputs 0, busy = 0; bits without sof are ignored; a subsequent normal frame passes.
